// File: rtl/gatebach_pkg.sv
// Shared sizing and state encoding for the gatebach survivor scan stage.
package gatebach_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 100;
  localparam int ADDR_W    = 7;
  localparam int NUM_W     = 64;
  localparam int CNT_W     = 12;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    DONE    = 2'd2
  } scan_state_t;

endpackage

// File: rtl/gatebach_lsb_find.sv
// Combinational lowest-set-bit encoder for one bitmap word.
module gatebach_lsb_find
  import gatebach_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [4:0]        index,
  output logic              any
);

  always_comb begin
    index = 5'd0;
    any   = |word;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (word[i]) index = 5'(i);
    end
  end

endmodule

// File: rtl/gatebach_survivor_scan.sv
// Captures the sieve bitmap from gatebach_core and streams surviving odd numbers.
// Optional macro GATEBACH_SCAN_LIMIT_EN adds cand_limit to stop after N candidates.
//
// state   | meaning
// COLLECT | accept bitmap words from the core, wait for store_done rising edge
// SCAN    | walk the bitmap word by word, emit one candidate per set bit
// DONE    | all survivors emitted (or limit hit); wait for clear
module gatebach_survivor_scan
  import gatebach_pkg::*;
(
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic [NUM_W-1:0]  start_addr,
  input  logic              store_done,
  input  logic              cs_in,
  input  logic [ADDR_W-1:0] add_in,
  input  logic [WORD_W-1:0] data_in,
  input  logic              clear,
`ifdef GATEBACH_SCAN_LIMIT_EN
  input  logic [CNT_W-1:0]  cand_limit,
`endif
  output logic              cand_valid,
  input  logic              cand_ready,
  output logic [NUM_W-1:0]  cand_num,
  output logic              scan_done,
  output logic [CNT_W-1:0]  survivor_cnt,
  output logic              busy
);

  logic [WORD_W-1:0]    mem [NUM_WORDS];
  logic [NUM_WORDS-1:0] flag;
  scan_state_t          state;
  logic                 sd_q;
  logic                 loaded;
  logic [ADDR_W-1:0]    ptr;
  logic [ADDR_W-1:0]    load_idx;
  logic [WORD_W-1:0]    work;
  logic [WORD_W-1:0]    work_eff;
  logic [WORD_W-1:0]    load_word;
  logic [NUM_W-1:0]     base;
  logic [4:0]           lsb_idx;
  logic                 lsb_any;
  logic                 hs;
  logic                 wr_en;
  logic                 last_word;
  logic                 limit_hit;
  logic [CNT_W-1:0]     cnt_inc;

  gatebach_lsb_find u_lsb_find (
    .word  (work_eff),
    .index (lsb_idx),
    .any   (lsb_any)
  );

  // The presented candidate is always the lowest set bit of work, so a
  // handshake simply strips that bit before looking for the next one.
  always_comb begin
    hs        = cand_valid & cand_ready;
    work_eff  = hs ? (work & (work - WORD_W'(1))) : work;
    load_idx  = loaded ? (ptr + ADDR_W'(1)) : ptr;
    load_word = flag[load_idx] ? mem[load_idx] : '1;
    wr_en     = (state == COLLECT) && cs_in && !clear && (add_in < ADDR_W'(NUM_WORDS));
    last_word = (ptr == ADDR_W'(NUM_WORDS - 1));
    cnt_inc   = survivor_cnt + CNT_W'(1);
`ifdef GATEBACH_SCAN_LIMIT_EN
    limit_hit = (cand_limit != '0) && (cnt_inc == cand_limit);
`else
    limit_hit = 1'b0;
`endif
  end

  // Repeated writes to a word AND together: a bit survives only if no pass removed it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[add_in] <= flag[add_in] ? (mem[add_in] & data_in) : data_in;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= COLLECT;
      flag         <= '0;
      sd_q         <= 1'b0;
      loaded       <= 1'b0;
      ptr          <= '0;
      work         <= '0;
      base         <= '0;
      cand_valid   <= 1'b0;
      cand_num     <= '0;
      scan_done    <= 1'b0;
      survivor_cnt <= '0;
      busy         <= 1'b0;
    end else begin
      sd_q <= store_done;
      if (clear) begin
        state        <= COLLECT;
        flag         <= '0;
        cand_valid   <= 1'b0;
        scan_done    <= 1'b0;
        survivor_cnt <= '0;
        busy         <= 1'b0;
      end else begin
        case (state)
          COLLECT: begin
            if (wr_en) flag[add_in] <= 1'b1;
            if (store_done && !sd_q) begin
              base   <= start_addr;
              ptr    <= '0;
              loaded <= 1'b0;
              work   <= '0;
              busy   <= 1'b1;
              state  <= SCAN;
            end
          end
          SCAN: begin
            if (!loaded) begin
              work   <= load_word;
              loaded <= 1'b1;
            end else begin
              if (hs) survivor_cnt <= cnt_inc;
              if (hs && limit_hit) begin
                cand_valid <= 1'b0;
                busy       <= 1'b0;
                scan_done  <= 1'b1;
                state      <= DONE;
              end else if (lsb_any) begin
                work       <= work_eff;
                cand_valid <= 1'b1;
                cand_num   <= base + NUM_W'({ptr, lsb_idx, 1'b0});
              end else begin
                cand_valid <= 1'b0;
                if (last_word) begin
                  busy      <= 1'b0;
                  scan_done <= 1'b1;
                  state     <= DONE;
                end else begin
                  ptr  <= ptr + ADDR_W'(1);
                  work <= load_word;
                end
              end
            end
          end
          DONE: begin
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

endmodule
